// File: rtl/angle_pkg.sv
// Shared constants, direction encoding and angle step helper for angle_selector.
package angle_pkg;
  localparam int ANGLE_W             = 4;
  localparam int ANGLE_STEPS         = 16;
  localparam int NUM_BTNS            = 2;
  localparam int BTN_RIGHT           = 0;
  localparam int BTN_LEFT            = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {DIR_NONE, DIR_PLUS, DIR_MINUS} dir_e;

  // ANGLE_W-bit arithmetic gives the mod-16 wrap for free.
  function automatic logic [ANGLE_W-1:0] angle_step(input logic [ANGLE_W-1:0] a, input dir_e d);
    case (d)
      DIR_PLUS:  return a + ANGLE_W'(1);
      DIR_MINUS: return a - ANGLE_W'(1);
      default:   return a;
    endcase
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debouncer, rising-edge press pulse.
module btn_debounce
  import angle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_pipe;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe  <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_pipe  <= {sync_pipe[0], btn};
      level_prev <= level;
      if (sync_pipe[1] == level)
        cnt <= '0;
      // Flip on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
      else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign press = level & ~level_prev;
endmodule

// File: rtl/angle_selector.sv
// Button-driven 4-bit aim angle. Define ANGLE_AUTOREPEAT_EN to enable hold-to-repeat stepping.
module angle_selector
  import angle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_ANGLE     = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_right,
  input  logic               btn_left,
  output logic [ANGLE_W-1:0] current_angle,
  output logic               angle_changed
);
  localparam logic [ANGLE_W-1:0] ANGLE_INIT = ANGLE_W'(RESET_ANGLE % ANGLE_STEPS);

  logic [NUM_BTNS-1:0] btn_raw, level, press;
  dir_e press_dir, rpt_dir, step_dir;

  assign btn_raw[BTN_RIGHT] = btn_right;
  assign btn_raw[BTN_LEFT]  = btn_left;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  // Simultaneous presses cancel out.
  always_comb begin
    press_dir = DIR_NONE;
    if (press[BTN_RIGHT] && !press[BTN_LEFT])
      press_dir = DIR_PLUS;
    else if (press[BTN_LEFT] && !press[BTN_RIGHT])
      press_dir = DIR_MINUS;
  end

`ifdef ANGLE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;  // first (delay) repeat already fired
  logic             one_held, rpt_fire;

  assign one_held = level[BTN_RIGHT] ^ level[BTN_LEFT];
  assign rpt_fire = one_held && !(|press) &&
                    (rpt_cnt == (rpt_armed ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (|press || !one_held) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else
      rpt_cnt <= rpt_cnt + 1'b1;
  end

  always_comb begin
    rpt_dir = DIR_NONE;
    if (rpt_fire)
      rpt_dir = level[BTN_RIGHT] ? DIR_PLUS : DIR_MINUS;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{level, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rpt_dir    = DIR_NONE;
`endif

  assign step_dir = (press_dir != DIR_NONE) ? press_dir : rpt_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_angle <= ANGLE_INIT;
      angle_changed <= 1'b0;
    end else begin
      angle_changed <= (step_dir != DIR_NONE);
      if (step_dir != DIR_NONE)
        current_angle <= angle_step(current_angle, step_dir);
    end
  end
endmodule

// File: tb/tb_angle_selector.sv
// Self-checking bench for angle_selector: directed scenarios plus random button activity
// checked against a time-window reference model.
module tb_angle_selector;
  localparam int D = 4, RD = 20, RP = 8;

  logic       clk = 1'b0, reset = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
  logic [3:0] current_angle;
  logic       angle_changed;

  always #5 clk = ~clk;

  angle_selector #(.DEBOUNCE_CYCLES(D), .RESET_ANGLE(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_right     (btn_right),
    .btn_left      (btn_left),
    .current_angle (current_angle),
    .angle_changed (angle_changed)
  );

  int total = 0, bad = 0, pulses = 0, p0;

  // Reference model: raw samples per edge; a level is accepted once the D samples that
  // have reached the debouncer (2-edge sync delay) all disagree with the current level.
  bit hist[2][$];
  bit m_lev[2], m_prs[2], m_chg;
  int m_angle, m_run;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      hist[b].delete();
      for (int i = 0; i < D + 2; i++) hist[b].push_back(1'b0);
      m_lev[b] = 1'b0;
      m_prs[b] = 1'b0;
    end
    m_angle = 0; m_chg = 1'b0; m_run = 0;
  endfunction

  function automatic void model_edge(bit r, bit l);
    int  step;
    bit  flip;
    bit  raw[2];
    step = 0; raw[0] = r; raw[1] = l;
    if (m_prs[0] && !m_prs[1]) step = 1;
    else if (m_prs[1] && !m_prs[0]) step = -1;
`ifdef ANGLE_AUTOREPEAT_EN
    if (m_prs[0] || m_prs[1]) m_run = 0;
    else if (m_lev[0] != m_lev[1]) begin
      m_run++;
      if (m_run == RD || (m_run > RD && (m_run - RD) % RP == 0)) step = m_lev[0] ? 1 : -1;
    end else m_run = 0;
`endif
    m_chg   = (step != 0);
    m_angle = (m_angle + step + 16) % 16;
    for (int b = 0; b < 2; b++) begin
      hist[b].push_back(raw[b]);
      if (hist[b].size() > D + 3) void'(hist[b].pop_front());
      flip = 1'b1;
      for (int i = 0; i < D; i++)
        if (hist[b][hist[b].size() - 3 - i] == m_lev[b]) flip = 1'b0;
      m_prs[b] = 1'b0;
      if (flip) begin
        m_lev[b] = !m_lev[b];
        m_prs[b] = m_lev[b];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge(btn_right, btn_left);
      #1;
      chk("angle", current_angle, m_angle);
      chk("changed", angle_changed, m_chg);
      if (angle_changed === 1'b1) pulses++;
    end
  endtask

  task automatic press(input bit right, input int hold);
    if (right) btn_right = 1'b1; else btn_left = 1'b1;
    tick(hold);
    btn_right = 1'b0; btn_left = 1'b0;
    tick(D + 4);
  endtask

  initial begin
    model_reset();
    tick(3);
    chk("rst_angle", current_angle, 0);
    chk("rst_changed", angle_changed, 0);
    #2 reset = 1'b1;

    // Press latency: update on the 7th edge counting the first sampling edge.
    btn_right = 1'b1;
    tick(6);
    chk("lat_before", current_angle, 0);
    tick(1);
    chk("lat_edge7", current_angle, 1);
    chk("lat_pulse", angle_changed, 1);
    tick(1);
    chk("pulse_one_cycle", angle_changed, 0);
    btn_right = 1'b0;
    tick(D + 4);

    // Glitch shorter than D is ignored.
    btn_left = 1'b1; tick(3); btn_left = 1'b0; tick(D + 6);
    chk("glitch", current_angle, 1);
    press(1'b0, 8);
    chk("left_to0", current_angle, 0);
    press(1'b0, 8);
    chk("wrap_0_to_15", current_angle, 15);
    press(1'b1, 8);
    chk("wrap_15_to_0", current_angle, 0);

    p0 = pulses;
    for (int k = 0; k < 16; k++) press(1'b1, 8);
    chk("wrap16_angle", current_angle, 0);
    chk("wrap16_pulses", pulses - p0, 16);

    // Both buttons in the same cycle: no step, no pulse.
    p0 = pulses;
    btn_right = 1'b1; btn_left = 1'b1;
    tick(D + 24);
    chk("both_angle", current_angle, 0);
    chk("both_pulses", pulses - p0, 0);
    btn_right = 1'b0; btn_left = 1'b0;
    tick(D + 4);

    // Asynchronous reset mid-debounce at angle 9.
    for (int k = 0; k < 9; k++) press(1'b1, 8);
    chk("at9", current_angle, 9);
    btn_right = 1'b1;
    tick(3);
    #2 reset = 1'b0;
    #1 chk("async_reset", current_angle, 0);
    model_reset();
    tick(2);
    #2 reset = 1'b1;
    tick(D + 2);
    chk("redebounce_before", current_angle, 0);
    tick(1);
    chk("redebounce_step", current_angle, 1);
    btn_right = 1'b0;
    tick(D + 4);

    // Long hold: repeats at +20,+28,+36,+44,+52 after acceptance when enabled.
    #2 reset = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    btn_right = 1'b1;
    tick(D + 3);
    chk("hold_accept", current_angle, 1);
    tick(59);
`ifdef ANGLE_AUTOREPEAT_EN
    chk("hold_repeat", current_angle, 6);
`else
    chk("hold_repeat", current_angle, 1);
`endif
    btn_right = 1'b0;
    tick(D + 4);

    // Random button activity against the model.
    for (int k = 0; k < 60; k++) begin
      btn_right = 1'($urandom_range(0, 1));
      btn_left  = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 14));
    end
    btn_right = 1'b0; btn_left = 1'b0;
    tick(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
